dec_scan_n: RTL and testbench
=============================

Name: dec_scan_n

Overview:
- Parametrised, registered 1-of-2^SEL_W decoder with enable. Next generation of the team's combinational 2-to-4 decoder.
- Adds a scan mode: an internal prescaler and index counter walk the active output around the ring, e.g. to drive digit selects for multiplexed 7-segment displays.
- Sits between control logic (select/enable) and the display or bank-select lines.
- All outputs are registered.

Parameters:
- SEL_W, 2, select width; output count N = 2^SEL_W (derived, not overridable).
- DIV, 4, clock cycles per scan step; legal range DIV >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- e  input  1  enable; 0 forces all outputs low.
- mode  input  1  0 = direct decode of s; 1 = auto-scan.
- s  input  SEL_W  select in direct mode; start index when scan is entered.
- o  output  N  one-hot (or all-zero) decoded output, registered.
- idx  output  SEL_W  index currently decoded on o, registered.
- tick  output  1  one-cycle pulse on the cycle idx advances in scan mode.

Behaviour:
- Reset (rst=1 at an edge): state=OFF, o=0, idx=0, prescaler=0, tick=0.
  - rst has priority over all other inputs.
  - rst mid-scan aborts the scan immediately.
- FSM states OFF, DIRECT, SCAN. Next state is evaluated every edge:
  - e=0 -> OFF.
  - e=1, mode=0 -> DIRECT.
  - e=1, mode=1 -> SCAN.
- OFF:
  - o<=0, tick<=0, prescaler<=0.
  - idx holds its last value.
- DIRECT:
  - idx<=s, o<=1<<s, tick<=0, prescaler<=0.
  - Latency: one clock from s/e/mode sampled to o.
- SCAN entry (previous state not SCAN):
  - idx<=s, o<=1<<s, prescaler<=0, tick<=0.
- SCAN, staying in SCAN:
  - If prescaler==DIV-1: prescaler<=0, idx<=idx+1 mod N, o<=1<<(idx+1 mod N), tick<=1.
  - Otherwise: prescaler<=prescaler+1, tick<=0; idx and o hold.
  - s is ignored while staying in SCAN.
- Resulting step timing: the first advance occurs DIV edges after the entry edge, then every DIV edges.
- Wrap-around: idx=N-1 advances to 0; o goes from MSB-only to LSB-only.
- DIV=1: idx advances on every edge after entry; tick stays high continuously.
- Prescaler width: clog2(DIV), minimum 1 bit. The counter never exceeds DIV-1.
- Invariant: o is all-zero or exactly one-hot, always equal to 1<<idx when state != OFF.
- Mode switch SCAN->DIRECT: takes s on the next edge. DIRECT->SCAN: restarts from the current s with prescaler=0.
- Dropping e for one cycle mid-scan then raising it restarts the scan from s; position is not resumed.

Optional Feature:
- Macro DEC_SCAN_DIR_EN.
- Defined:
  - Adds input port dir (1 bit).
  - In SCAN, dir=0 steps idx up (+1 mod N); dir=1 steps down (-1 mod N, 0 wraps to N-1).
  - dir is sampled only on advance edges; a dir change between advances affects the next step only.
- Undefined:
  - No dir port; SCAN always steps up.
  - All other behaviour is identical in both builds.

Test Plan:
Scenarios 1–4 use SEL_W=2, DIV=3.
1. Reset/off: rst=1 for 2 edges, then e=0, mode=X, s=3 for 3 edges -> o=0000, idx=0, tick=0 throughout.
2. Direct sweep: e=1, mode=0, s=0,1,2,3 on successive edges -> one edge later o=0001,0010,0100,1000 with idx matching; tick stays 0.
3. Scan with wrap: e=1, mode=1, s=2 at entry edge E0 -> o=0100 after E0.
   - E3: o=1000, idx=3, tick=1 for that cycle only.
   - E6: o=0001, idx=0, tick=1.
   - E9: o=0010.
   - Changing s during the scan has no effect.
4. Disable mid-scan: scan from s=0, drop e at prescaler=1 for one edge (o=0000), raise e with mode=1, s=3 -> o=1000; next advance 3 edges later to 0001.
5. DIV=1, SEL_W=3: scan from s=6 -> o=0x40, 0x80, 0x01, 0x02 on consecutive edges; tick=1 on every advance edge.
6. Sync reset mid-scan, then direction (DEC_SCAN_DIR_EN defined):
   - rst=1 at an advance edge -> o=0, idx=0, tick=0 on that edge; no advance.
   - Then scan from s=0 with dir=1 -> idx 0,3,2,1,0 every 3 edges.

Source files
------------

// File: rtl/dec_scan_n_if.sv
// -----------------------------------------------------------------------------
// dec_scan_n_if
//   Bundle between control logic and the dec_scan_n decoder.
//   Build option: DEC_SCAN_DIR_EN adds the 'dir' scan-direction signal.
//
//   Signals:
//     e     control -> decoder  enable; 0 forces all outputs low
//     mode  control -> decoder  0 = direct decode of s, 1 = auto-scan
//     s     control -> decoder  select / scan start index (SEL_W bits)
//     dir   control -> decoder  scan direction, 0 = up, 1 = down (option)
//     o     decoder -> control  registered one-hot (or all-zero) output
//     idx   decoder -> control  registered index currently shown on o
//     tick  decoder -> control  one-cycle pulse when idx advances in scan
// -----------------------------------------------------------------------------
interface dec_scan_n_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             e;
  logic             mode;
  logic [SEL_W-1:0] s;
`ifdef DEC_SCAN_DIR_EN
  logic             dir;
`endif
  logic [N-1:0]     o;
  logic [SEL_W-1:0] idx;
  logic             tick;

`ifdef DEC_SCAN_DIR_EN
  modport master (output e, mode, s, dir, input o, idx, tick);
  modport slave  (input e, mode, s, dir, output o, idx, tick);
`else
  modport master (output e, mode, s, input o, idx, tick);
  modport slave  (input e, mode, s, output o, idx, tick);
`endif
endinterface

// File: rtl/dec_scan_n.sv
// -----------------------------------------------------------------------------
// dec_scan_n
//   Registered 1-of-2^SEL_W decoder with enable and an auto-scan mode that
//   walks the active output around the ring every DIV clocks (e.g. digit
//   selects of a multiplexed 7-segment display).
//   Build option: DEC_SCAN_DIR_EN adds a scan direction input (bus.dir).
//
//   Ports:
//     clk  clock, all state on rising edge
//     rst  synchronous, active-high reset (priority over everything)
//     bus  dec_scan_n_if.slave: e, mode, s, [dir] in; o, idx, tick out
//
//   Parameters:
//     SEL_W  select width, output count N = 2^SEL_W
//     DIV    clock cycles per scan step, DIV >= 1
// -----------------------------------------------------------------------------
module dec_scan_n #(
  parameter int SEL_W = 2,
  parameter int DIV   = 4
) (
  input  logic          clk,
  input  logic          rst,
  dec_scan_n_if.slave   bus
);
  localparam int N  = 1 << SEL_W;
  // Prescaler is at least one bit wide so DIV=1 still has a legal register.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e           state_q;
  logic [N-1:0]     o_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic             tick_q;
  logic [PW-1:0]    presc_q;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  // Index the scan moves to on an advance edge; modulo-N wrap comes free
  // from the SEL_W-bit arithmetic.
  always_comb begin
`ifdef DEC_SCAN_DIR_EN
    idx_d = bus.dir ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
`else
    idx_d = idx_q + SEL_W'(1);
`endif
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values of each other, as the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      o_q     <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else if (!bus.e) begin
      // idx deliberately holds its last value while off.
      state_q <= ST_OFF;
      o_q     <= '0;
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else if (!bus.mode) begin
      state_q <= ST_DIRECT;
      idx_q   <= bus.s;
      o_q     <= onehot(bus.s);
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else if (state_q != ST_SCAN) begin
      // Scan entry always restarts from s; a previous position is not resumed.
      state_q <= ST_SCAN;
      idx_q   <= bus.s;
      o_q     <= onehot(bus.s);
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else if (presc_q == PRESC_MAX) begin
      idx_q   <= idx_d;
      o_q     <= onehot(idx_d);
      tick_q  <= 1'b1;
      presc_q <= '0;
    end else begin
      tick_q  <= 1'b0;
      presc_q <= presc_q + PW'(1);
    end
  end

  assign bus.o    = o_q;
  assign bus.idx  = idx_q;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_dec_scan_n.sv
module tb_dec_scan_n;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dec_scan_n_if #(.SEL_W(2)) bus1 ();
  dec_scan_n_if #(.SEL_W(3)) bus2 ();

  dec_scan_n #(.SEL_W(2), .DIV(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  dec_scan_n #(.SEL_W(3), .DIV(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [3:0] o, input logic [1:0] idx, input logic tick);
    check({tag, ".o"},    32'(bus1.o),    32'(o));
    check({tag, ".idx"},  32'(bus1.idx),  32'(idx));
    check({tag, ".tick"}, 32'(bus1.tick), 32'(tick));
  endtask

  task automatic chk2(input string tag, input logic [7:0] o, input logic [2:0] idx, input logic tick);
    check({tag, ".o"},    32'(bus2.o),    32'(o));
    check({tag, ".idx"},  32'(bus2.idx),  32'(idx));
    check({tag, ".tick"}, 32'(bus2.tick), 32'(tick));
  endtask

  // Expected o / tick after edges E1..E9 of the wrap scan (entry s=2, DIV=3).
  logic [3:0] scan_o    [1:9] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                                  4'b0001, 4'b0001, 4'b0001, 4'b0010};
  logic [1:0] scan_idx  [1:9] = '{2, 2, 3, 3, 3, 0, 0, 0, 1};
  logic       scan_tick [1:9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus1.e = 1'b0; bus1.mode = 1'b0; bus1.s = '0;
    bus2.e = 1'b0; bus2.mode = 1'b0; bus2.s = '0;
`ifdef DEC_SCAN_DIR_EN
    bus1.dir = 1'b0; bus2.dir = 1'b0;
`endif

    // 1. Reset, then disabled with s=3.
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("reset", 4'b0000, 2'd0, 1'b0);
    end
    rst = 1'b0; bus1.e = 1'b0; bus1.mode = 1'b1; bus1.s = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("off", 4'b0000, 2'd0, 1'b0);
    end

    // 2. Direct sweep.
    bus1.e = 1'b1; bus1.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus1.s = 2'(i);
      step();
      chk1("direct", 4'(1 << i), 2'(i), 1'b0);
    end

    // 3. Scan with wrap; s wiggles after entry and must be ignored.
    bus1.mode = 1'b1; bus1.s = 2'd2;
    step();
    chk1("scan_e0", 4'b0100, 2'd2, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      bus1.s = 2'(k);
      step();
      chk1($sformatf("scan_e%0d", k), scan_o[k], scan_idx[k], scan_tick[k]);
    end

    // 4. Disable for one edge mid-scan, then restart from s=3.
    bus1.e = 1'b0;
    step();
    bus1.e = 1'b1; bus1.mode = 1'b1; bus1.s = 2'd0;
    step();
    chk1("dis_entry", 4'b0001, 2'd0, 1'b0);
    step();                                  // prescaler now 1
    bus1.e = 1'b0;
    step();
    chk1("dis_off", 4'b0000, 2'd0, 1'b0);
    bus1.e = 1'b1; bus1.s = 2'd3;
    step();
    chk1("dis_restart", 4'b1000, 2'd3, 1'b0);
    step();
    step();
    chk1("dis_hold", 4'b1000, 2'd3, 1'b0);
    step();
    chk1("dis_adv", 4'b0001, 2'd0, 1'b1);

    // 5. DIV=1, SEL_W=3 scan from 6: advances every edge.
    bus1.e = 1'b0;
    bus2.e = 1'b1; bus2.mode = 1'b1; bus2.s = 3'd6;
    step();
    chk2("div1_entry", 8'h40, 3'd6, 1'b0);
    step();
    chk2("div1_a1", 8'h80, 3'd7, 1'b1);
    step();
    chk2("div1_a2", 8'h01, 3'd0, 1'b1);
    step();
    chk2("div1_a3", 8'h02, 3'd1, 1'b1);
    bus2.e = 1'b0;

    // 6. Reset on an advance edge, then scan (down if dir is built in).
    bus1.e = 1'b1; bus1.mode = 1'b1; bus1.s = 2'd1;
    step();                                  // entry at idx 1
    step();
    step();                                  // prescaler = 2, next edge advances
    rst = 1'b1;
    step();
    chk1("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; bus1.s = 2'd0;
`ifdef DEC_SCAN_DIR_EN
    bus1.dir = 1'b1;
`endif
    step();
    chk1("dir_entry", 4'b0001, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] exp_idx;
`ifdef DEC_SCAN_DIR_EN
      exp_idx = 2'(4 - k);
`else
      exp_idx = 2'(k);
`endif
      step();
      step();
      check($sformatf("dir_hold%0d", k), 32'(bus1.tick), 32'd0);
      step();
      chk1($sformatf("dir_step%0d", k), 4'(1 << exp_idx), exp_idx, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
